// File: rtl/pcie_tl_pkg.sv
// pcie_tl_pkg: transaction-layer state encodings
// shared by control_fsm and the counters block.
package pcie_tl_pkg;

  localparam int STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    ST_ERROR  = 4'b0000,
    ST_RESET  = 4'b0001,
    ST_INIT   = 4'b0010,
    ST_IDLE   = 4'b0100,
    ST_ACTIVE = 4'b1000
  } tl_state_e;

endpackage

// File: rtl/control_fsm_if.sv
// control_fsm_if: control/threshold bus between
// the upstream controller and control_fsm.
interface control_fsm_if #(
  parameter int NUM_FIFOS = 4,
  parameter int UMBRAL_W  = 3
);
  import pcie_tl_pkg::*;

  logic                 init;
  logic [NUM_FIFOS-1:0] fifo_empty;
  logic [NUM_FIFOS-1:0] fifo_error;
  logic [UMBRAL_W-1:0]  umbral_alto_in;
  logic [UMBRAL_W-1:0]  umbral_bajo_in;
  logic [STATE_W-1:0]   state;
  logic                 idle;
  logic [UMBRAL_W-1:0]  umbral_alto;
  logic [UMBRAL_W-1:0]  umbral_bajo;
  logic [NUM_FIFOS-1:0] error_out;

  modport master (
    output init,
    output fifo_empty,
    output fifo_error,
    output umbral_alto_in,
    output umbral_bajo_in,
    input  state,
    input  idle,
    input  umbral_alto,
    input  umbral_bajo,
    input  error_out
  );

  modport slave (
    input  init,
    input  fifo_empty,
    input  fifo_error,
    input  umbral_alto_in,
    input  umbral_bajo_in,
    output state,
    output idle,
    output umbral_alto,
    output umbral_bajo,
    output error_out
  );

endinterface

// File: rtl/control_fsm_idle_timer.sv
// idle_timer: saturating count of consecutive
// all-empty cycles while ACTIVE.
module idle_timer #(
  parameter int IDLE_CYCLES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic all_empty,
  output logic expired
);

  localparam int CW = $clog2(IDLE_CYCLES + 1);
  localparam logic [CW-1:0] TARGET = CW'(IDLE_CYCLES);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;

  assign cnt_inc = (cnt == TARGET) ? cnt : cnt + CW'(1);

  // Fires on the edge the count would reach the target,
  // so the FSM leaves ACTIVE on that same edge.
  assign expired = enable && all_empty && (cnt_inc == TARGET);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (!enable || !all_empty || expired) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_inc;
    end
  end

endmodule

// File: rtl/control_fsm.sv
// control_fsm: TL sequencer RESET/INIT/IDLE/ACTIVE.
// Optional ERROR state under CONTROL_FSM_ERROR_EN.
module control_fsm
  import pcie_tl_pkg::*;
#(
  parameter int NUM_FIFOS   = 4,
  parameter int UMBRAL_W    = 3,
  parameter int IDLE_CYCLES = 2
) (
  input logic         clk,
  input logic         reset,
  control_fsm_if.slave bus
);

  tl_state_e st;
  tl_state_e nx;

  logic                 all_empty;
  logic                 any_err;
  logic                 err_hit;
  logic                 tmr_en;
  logic                 expired;
  logic                 idle_q;
  logic [UMBRAL_W-1:0]  alto_q;
  logic [UMBRAL_W-1:0]  bajo_q;
  logic [NUM_FIFOS-1:0] err_q;

  assign all_empty = &bus.fifo_empty;

`ifdef CONTROL_FSM_ERROR_EN
  assign any_err = |bus.fifo_error;
`else
  logic unused_err;
  assign unused_err = ^bus.fifo_error;
  assign any_err    = 1'b0;
`endif

  assign err_hit = any_err &&
                   (st == ST_IDLE || st == ST_ACTIVE);

  // Timer runs only while staying in ACTIVE, so every
  // exit clears it on the exit edge.
  assign tmr_en = (st == ST_ACTIVE) && !err_hit && !bus.init;

  idle_timer #(
    .IDLE_CYCLES(IDLE_CYCLES)
  ) u_idle_timer (
    .clk      (clk),
    .reset    (reset),
    .enable   (tmr_en),
    .all_empty(all_empty),
    .expired  (expired)
  );

  always_comb begin
    nx = st;
    unique case (st)
      ST_RESET: nx = ST_INIT;
      ST_INIT:  nx = bus.init ? ST_INIT : ST_IDLE;
      ST_IDLE: begin
        if (err_hit)         nx = ST_ERROR;
        else if (bus.init)   nx = ST_INIT;
        else if (!all_empty) nx = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (err_hit)       nx = ST_ERROR;
        else if (bus.init) nx = ST_INIT;
        else if (expired)  nx = ST_IDLE;
      end
      ST_ERROR: begin
        if (bus.init) nx = ST_INIT;
      end
      default: nx = ST_RESET;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st     <= ST_RESET;
      idle_q <= 1'b0;
      alto_q <= '0;
      bajo_q <= '0;
      err_q  <= '0;
    end else begin
      st     <= nx;
      idle_q <= (nx == ST_IDLE);
      if (st == ST_INIT) begin
        alto_q <= bus.umbral_alto_in;
        bajo_q <= (bus.umbral_bajo_in > bus.umbral_alto_in) ?
                  bus.umbral_alto_in : bus.umbral_bajo_in;
      end
`ifdef CONTROL_FSM_ERROR_EN
      if (nx == ST_INIT) begin
        err_q <= '0;
      end else if (st != ST_RESET && st != ST_INIT) begin
        err_q <= err_q | bus.fifo_error;
      end
`endif
    end
  end

  assign bus.state       = st;
  assign bus.idle        = idle_q;
  assign bus.umbral_alto = alto_q;
  assign bus.umbral_bajo = bajo_q;
  assign bus.error_out   = err_q;

endmodule
